l2_sync_responder: RTL

- L2-side responder for the per-core store buffer request/response protocol.
- Accepts l2req packets (STORE, STORE_SYNC, LOAD_SYNC, FLUSH, DINVALIDATE, IINVALIDATE) into a small FIFO.
- Resolves synchronized-store success against per-strand load-link reservations.
- Returns one l2rsp packet per request, in order, with the status bit the store buffer forwards as the sync store result.

---
 rtl/l2_sync_responder_pkg.sv | 53 +++++
 rtl/l2_sync_responder_fifo.sv | 56 +++++
 rtl/l2_sync_responder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/l2_sync_responder_pkg.sv
// Shared L2 request/response packet definitions for the store buffer interface.
// Also carries the strand count and the legality check for request ops.
`ifndef STRANDS_PER_CORE
`define STRANDS_PER_CORE 4
`endif

package l2_sync_responder_pkg;

    localparam int STRAND_WIDTH = $clog2(`STRANDS_PER_CORE);
    localparam int CORE_WIDTH   = 4;
    localparam int UNIT_WIDTH   = 2;
    localparam int ADDR_WIDTH   = 26;
    localparam int DATA_WIDTH   = 64;
    localparam int MASK_WIDTH   = 8;

    localparam logic [UNIT_WIDTH-1:0] UNIT_STBUF = 2'd1;

    typedef enum logic [2:0] {
        L2REQ_STORE       = 3'd0,
        L2REQ_STORE_SYNC  = 3'd1,
        L2REQ_LOAD_SYNC   = 3'd2,
        L2REQ_FLUSH       = 3'd3,
        L2REQ_DINVALIDATE = 3'd4,
        L2REQ_IINVALIDATE = 3'd5
    } l2req_packet_type_t;

    typedef struct packed {
        logic                    valid;
        logic [UNIT_WIDTH-1:0]   unit;
        logic [CORE_WIDTH-1:0]   core;
        logic [STRAND_WIDTH-1:0] strand;
        l2req_packet_type_t      op;
        logic [ADDR_WIDTH-1:0]   address;
        logic [DATA_WIDTH-1:0]   data;
        logic [MASK_WIDTH-1:0]   mask;
    } l2req_packet_t;

    typedef struct packed {
        logic                    valid;
        logic                    status;
        logic [CORE_WIDTH-1:0]   core;
        logic [UNIT_WIDTH-1:0]   unit;
        logic [STRAND_WIDTH-1:0] strand;
        l2req_packet_type_t      op;
        logic [ADDR_WIDTH-1:0]   address;
    } l2rsp_packet_t;

    function automatic logic is_legal_op(input l2req_packet_type_t op);
        return op inside {L2REQ_STORE, L2REQ_STORE_SYNC, L2REQ_LOAD_SYNC,
                          L2REQ_FLUSH, L2REQ_DINVALIDATE, L2REQ_IINVALIDATE};
    endfunction

endpackage

// File: rtl/l2_sync_responder_fifo.sv
// Generic synchronous FIFO; head data is combinational from storage, one cycle after push.
// full/empty come from a registered count only, so callers may drive ready from them directly.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/l2_sync_responder.sv
// L2 responder: queues store-buffer requests, resolves sync stores against per-strand reservations.
// Response is registered 2 cycles after accept, 1/cycle, no response backpressure; ready = !fifo_full.
module l2_sync_responder
    import l2_sync_responder_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int NUM_STRANDS = `STRANDS_PER_CORE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  l2req_packet_t          l2req_packet,
    output logic                   l2req_ready,
    output l2rsp_packet_t          l2rsp_packet,
    output logic [NUM_STRANDS-1:0] reservation_valid
);

    typedef struct packed {
        logic [UNIT_WIDTH-1:0]   unit;
        logic [CORE_WIDTH-1:0]   core;
        logic [STRAND_WIDTH-1:0] strand;
        l2req_packet_type_t      op;
        logic [ADDR_WIDTH-1:0]   address;
    } req_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] address;
    } res_entry_t;

    req_entry_t push_entry;
    req_entry_t head;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;

    res_entry_t res      [NUM_STRANDS];
    res_entry_t res_next [NUM_STRANDS];
    logic       own_hit;
    logic       rsp_status;

    // Payload is not echoed back; keep it visibly consumed.
    logic unused_req_bits;
    assign unused_req_bits = ^{l2req_packet.data, l2req_packet.mask};

    assign l2req_ready = !fifo_full;
    assign fifo_push   = l2req_packet.valid && l2req_ready;
    assign fifo_pop    = !fifo_empty;

    assign push_entry.unit    = l2req_packet.unit;
    assign push_entry.core    = l2req_packet.core;
    assign push_entry.strand  = l2req_packet.strand;
    assign push_entry.op      = l2req_packet.op;
    assign push_entry.address = l2req_packet.address;

    sync_fifo #(
        .WIDTH ($bits(req_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        own_hit = 1'b0;
        for (int j = 0; j < NUM_STRANDS; j++) begin
            if (head.strand == STRAND_WIDTH'(j))
                own_hit = res[j].valid && (res[j].address == head.address);
        end
    end

    always_comb begin
        res_next   = res;
        rsp_status = 1'b1;
        case (head.op)
            L2REQ_STORE: begin
                for (int j = 0; j < NUM_STRANDS; j++)
                    if (res[j].address == head.address)
                        res_next[j].valid = 1'b0;
            end
            L2REQ_STORE_SYNC: begin
                // A failed sync store has no write effect, so only the requester loses its link.
                rsp_status = own_hit;
                for (int j = 0; j < NUM_STRANDS; j++) begin
                    if (own_hit ? (res[j].address == head.address)
                                : (head.strand == STRAND_WIDTH'(j)))
                        res_next[j].valid = 1'b0;
                end
            end
            L2REQ_LOAD_SYNC: begin
                for (int j = 0; j < NUM_STRANDS; j++) begin
                    if (head.strand == STRAND_WIDTH'(j)) begin
                        res_next[j].valid   = 1'b1;
                        res_next[j].address = head.address;
                    end
                end
            end
            L2REQ_FLUSH, L2REQ_DINVALIDATE, L2REQ_IINVALIDATE: rsp_status = 1'b1;
            default: rsp_status = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l2rsp_packet <= '0;
            for (int j = 0; j < NUM_STRANDS; j++)
                res[j] <= '0;
        end else begin
            l2rsp_packet.valid <= fifo_pop;
            if (fifo_pop) begin
                l2rsp_packet.status  <= rsp_status;
                l2rsp_packet.core    <= head.core;
                l2rsp_packet.unit    <= head.unit;
                l2rsp_packet.strand  <= head.strand;
                l2rsp_packet.op      <= head.op;
                l2rsp_packet.address <= head.address;
                res                  <= res_next;
            end
        end
    end

    always_comb begin
        reservation_valid = '0;
        for (int j = 0; j < NUM_STRANDS; j++)
            reservation_valid[j] = res[j].valid;
    end

    a_legal_op: assert property (@(posedge clk) disable iff (reset)
        fifo_pop |-> is_legal_op(head.op));

endmodule
